// File: rtl/fetch_unit_if.sv
// Instruction-memory read channel between fetch_unit (master) and the memory (slave).
interface fetch_unit_if #(
    parameter int unsigned DWIDTH = 32
);
    logic              imem_req;
    logic [DWIDTH-1:0] imem_addr;
    logic              imem_ack;
    logic [DWIDTH-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit: IDLE -> FETCH -> VALID loop with branch/jump PC update.
// Define FETCH_MISALIGN_CHECK_EN to halt with a sticky fetch_err on a misaligned next PC.
module fetch_unit #(
    parameter int unsigned       DWIDTH   = 32,
    parameter logic [DWIDTH-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    fetch_unit_if.master      imem,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DWIDTH-1:0] Instr,
    output logic [6:0]        OP,
    output logic [2:0]        funct3,
    output logic [6:0]        funct7,
    output logic [DWIDTH-1:0] PC,
    output logic [DWIDTH-1:0] PCPlus4,
    input  logic              Branch,
    input  logic              Jump,
    input  logic              Zero,
    input  logic [DWIDTH-1:0] ImmExt,
    output logic              fetch_err
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        VALID,
        HALT
    } state_e;

    localparam logic [DWIDTH-1:0] PC_STEP = DWIDTH'(4);
    localparam logic [DWIDTH-1:0] NOP     = DWIDTH'(32'h0000_0013);

    state_e            state_q, state_d;
    logic [DWIDTH-1:0] pc_q, pc_d;
    logic [DWIDTH-1:0] instr_q, instr_d;
    logic [DWIDTH-1:0] next_pc;
    logic              take;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic err_q, err_d;
`endif

    // Additions wrap modulo 2^DWIDTH by construction.
    assign take    = Jump | (Branch & Zero);
    assign next_pc = take ? (pc_q + ImmExt) : (pc_q + PC_STEP);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
`ifdef FETCH_MISALIGN_CHECK_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (instr_ready) begin
`ifdef FETCH_MISALIGN_CHECK_EN
                    if (next_pc[1:0] != 2'b00) begin
                        state_d = HALT;
                        err_d   = 1'b1;
                    end else begin
                        pc_d    = next_pc;
                        state_d = FETCH;
                    end
`else
                    pc_d    = next_pc;
                    state_d = FETCH;
`endif
                end
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
`ifdef FETCH_MISALIGN_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign imem.imem_req  = (state_q == FETCH);
    assign imem.imem_addr = pc_q;
    assign instr_valid    = (state_q == VALID);
    assign Instr          = instr_q;
    assign PC             = pc_q;
    assign PCPlus4        = pc_q + PC_STEP;
    assign OP             = instr_q[6:0];
    assign funct3         = instr_q[14:12];
    assign funct7         = instr_q[31:25];

`ifdef FETCH_MISALIGN_CHECK_EN
    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized transactions against a PC model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] Instr;
    logic [6:0]  OP;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        Branch;
    logic        Jump;
    logic        Zero;
    logic [31:0] ImmExt;
    logic        fetch_err;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [31:0] exp_pc;

    fetch_unit_if #(.DWIDTH(32)) bus ();

    fetch_unit #(
        .DWIDTH   (32),
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (bus),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .Instr       (Instr),
        .OP          (OP),
        .funct3      (funct3),
        .funct7      (funct7),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .Branch      (Branch),
        .Jump        (Jump),
        .Zero        (Zero),
        .ImmExt      (ImmExt),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        instr_ready    = 1'b0;
        Branch         = 1'b0;
        Jump           = 1'b0;
        Zero           = 1'b0;
        ImmExt         = '0;
    endtask

    // Stimulus only: complete one fetch and accept it with the given branch decision.
    task automatic accept(input logic b, input logic j, input logic z, input logic [31:0] imm);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = $urandom;
        tick();
        bus.imem_ack = 1'b0;
        instr_ready  = 1'b1;
        Branch = b; Jump = j; Zero = z; ImmExt = imm;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", bus.imem_req); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", instr_valid); end
        n_cmp++; if (PC !== 32'h100) begin n_err++; $display("FAIL rst_pc got %h want 00000100", PC); end
        n_cmp++; if (Instr !== 32'h13) begin n_err++; $display("FAIL rst_instr got %h want 00000013", Instr); end
        n_cmp++; if (fetch_err !== 1'b0) begin n_err++; $display("FAIL rst_err got %b want 0", fetch_err); end
        rst = 1'b0;
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL rst_idle_req got %b want 0", bus.imem_req); end
        tick();
        n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL rst_first_req got %b want 1", bus.imem_req); end
        n_cmp++; if (bus.imem_addr !== 32'h100) begin n_err++; $display("FAIL rst_first_addr got %h want 00000100", bus.imem_addr); end
        exp_pc = 32'h100;
    endtask

    task automatic test_sequential;
        logic [31:0] word = '0;
        bus.imem_ack = 1'b1;
        instr_ready  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL seq_req[%0d] got %b want 1", i, bus.imem_req); end
                n_cmp++; if (bus.imem_addr !== exp_pc) begin n_err++; $display("FAIL seq_addr[%0d] got %h want %h", i, bus.imem_addr, exp_pc); end
                word = $urandom;
                bus.imem_rdata = word;
            end else begin
                n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL seq_noreq[%0d] got %b want 0", i, bus.imem_req); end
                n_cmp++; if (Instr !== word) begin n_err++; $display("FAIL seq_instr[%0d] got %h want %h", i, Instr, word); end
                exp_pc = exp_pc + 32'd4;
            end
            tick();
        end
        clear_inputs();
        n_cmp++; if (bus.imem_addr !== 32'h10C) begin n_err++; $display("FAIL seq_final_addr got %h want 0000010c", bus.imem_addr); end
    endtask

    task automatic test_branch;
        accept(1'b0, 1'b1, 1'b0, 32'h200 - exp_pc);
        n_cmp++; if (bus.imem_addr !== 32'h200) begin n_err++; $display("FAIL br_jump_addr got %h want 00000200", bus.imem_addr); end
        accept(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF0);
        n_cmp++; if (bus.imem_addr !== 32'h1F0) begin n_err++; $display("FAIL br_taken_addr got %h want 000001f0", bus.imem_addr); end
        accept(1'b0, 1'b1, 1'b0, 32'h10);
        accept(1'b1, 1'b0, 1'b0, 32'hFFFF_FFF0);
        n_cmp++; if (bus.imem_addr !== 32'h204) begin n_err++; $display("FAIL br_nottaken_addr got %h want 00000204", bus.imem_addr); end
        accept(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC - 32'h204);
        n_cmp++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL br_top_addr got %h want fffffffc", bus.imem_addr); end
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        n_cmp++; if (PCPlus4 !== 32'h0) begin n_err++; $display("FAIL wrap_pcplus4 got %h want 00000000", PCPlus4); end
        instr_ready = 1'b1;
        tick();
        clear_inputs();
        n_cmp++; if (bus.imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr got %h want 00000000", bus.imem_addr); end
        exp_pc = 32'h0;
    endtask

    task automatic test_ack_delay;
        logic [31:0] word;
        word = $urandom;
        for (int k = 0; k < 3; k++) begin
            n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL ackd_req[%0d] got %b want 1", k, bus.imem_req); end
            n_cmp++; if (bus.imem_addr !== exp_pc) begin n_err++; $display("FAIL ackd_addr[%0d] got %h want %h", k, bus.imem_addr, exp_pc); end
            n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL ackd_valid[%0d] got %b want 0", k, instr_valid); end
            instr_ready    = 1'b1;
            bus.imem_rdata = $urandom;
            tick();
        end
        n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL ackd_req_last got %b want 1", bus.imem_req); end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
        instr_ready    = 1'b0;
        tick();
        bus.imem_ack = 1'b0;
        n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL ackd_valid_rise got %b want 1", instr_valid); end
        n_cmp++; if (Instr !== word) begin n_err++; $display("FAIL ackd_instr got %h want %h", Instr, word); end
        instr_ready = 1'b1;
        tick();
        clear_inputs();
        exp_pc = exp_pc + 32'd4;
    endtask

    task automatic test_ready_stall;
        logic [31:0] word;
        word = $urandom;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
        tick();
        for (int k = 0; k < 5; k++) begin
            n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d] got %b want 1", k, instr_valid); end
            n_cmp++; if (Instr !== word) begin n_err++; $display("FAIL stall_instr[%0d] got %h want %h", k, Instr, word); end
            n_cmp++; if (PC !== exp_pc) begin n_err++; $display("FAIL stall_pc[%0d] got %h want %h", k, PC, exp_pc); end
            n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req[%0d] got %b want 0", k, bus.imem_req); end
            instr_ready    = 1'b0;
            Branch         = ~Branch;
            Zero           = 1'b1;
            Jump           = (k % 2) == 1;
            ImmExt         = 32'h40;
            bus.imem_ack   = 1'($urandom_range(0, 1));
            bus.imem_rdata = $urandom;
            tick();
        end
        clear_inputs();
        instr_ready = 1'b1;
        tick();
        clear_inputs();
        exp_pc = exp_pc + 32'd4;
        n_cmp++; if (bus.imem_addr !== exp_pc) begin n_err++; $display("FAIL stall_next_addr got %h want %h", bus.imem_addr, exp_pc); end
    endtask

    task automatic test_reset_mid;
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        rst            = 1'b1;
        tick();
        clear_inputs();
        n_cmp++; if (Instr !== 32'h13) begin n_err++; $display("FAIL rstf_instr got %h want 00000013", Instr); end
        n_cmp++; if (PC !== 32'h100) begin n_err++; $display("FAIL rstf_pc got %h want 00000100", PC); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rstf_valid got %b want 0", instr_valid); end
        rst = 1'b0;
        tick();
        bus.imem_ack = 1'b1;
        tick();
        bus.imem_ack = 1'b0;
        instr_ready  = 1'b1;
        Jump         = 1'b1;
        ImmExt       = 32'h40;
        rst          = 1'b1;
        tick();
        clear_inputs();
        n_cmp++; if (PC !== 32'h100) begin n_err++; $display("FAIL rstv_pc got %h want 00000100", PC); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL rstv_valid got %b want 0", instr_valid); end
        rst = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.imem_addr !== 32'h100) begin n_err++; $display("FAIL rstv_addr got %h want 00000100", bus.imem_addr); end
        exp_pc = 32'h100;
    endtask

    task automatic test_random;
        for (int t = 0; t < 40; t++) begin
            int unsigned ad = $urandom_range(0, 3);
            int unsigned rd = $urandom_range(0, 3);
            logic [31:0] word = $urandom;
            logic        b = 1'($urandom_range(0, 1));
            logic        j = ($urandom_range(0, 3) == 0);
            logic        z = 1'($urandom_range(0, 1));
            logic [31:0] imm = $urandom & 32'hFFFF_FFFC;
            for (int k = 0; k < int'(ad); k++) begin
                n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL rnd_req[%0d] got %b want 1", t, bus.imem_req); end
                n_cmp++; if (bus.imem_addr !== exp_pc) begin n_err++; $display("FAIL rnd_addr[%0d] got %h want %h", t, bus.imem_addr, exp_pc); end
                bus.imem_ack = 1'b0;
                instr_ready  = 1'($urandom_range(0, 1));
                tick();
            end
            n_cmp++; if (bus.imem_addr !== exp_pc) begin n_err++; $display("FAIL rnd_ackaddr[%0d] got %h want %h", t, bus.imem_addr, exp_pc); end
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = word;
            instr_ready    = 1'b0;
            tick();
            for (int k = 0; k < int'(rd); k++) begin
                n_cmp++; if (Instr !== word) begin n_err++; $display("FAIL rnd_hold[%0d] got %h want %h", t, Instr, word); end
                n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL rnd_noreq[%0d] got %b want 0", t, bus.imem_req); end
                bus.imem_ack   = 1'($urandom_range(0, 1));
                bus.imem_rdata = $urandom;
                instr_ready    = 1'b0;
                Branch = 1'($urandom_range(0, 1)); Jump = 1'($urandom_range(0, 1));
                Zero = 1'($urandom_range(0, 1)); ImmExt = $urandom;
                tick();
            end
            n_cmp++; if (instr_valid !== 1'b1) begin n_err++; $display("FAIL rnd_valid[%0d] got %b want 1", t, instr_valid); end
            n_cmp++; if (PC !== exp_pc) begin n_err++; $display("FAIL rnd_pc[%0d] got %h want %h", t, PC, exp_pc); end
            n_cmp++; if (PCPlus4 !== exp_pc + 32'd4) begin n_err++; $display("FAIL rnd_pcp4[%0d] got %h want %h", t, PCPlus4, exp_pc + 32'd4); end
            n_cmp++; if (OP !== word[6:0]) begin n_err++; $display("FAIL rnd_op[%0d] got %h want %h", t, OP, word[6:0]); end
            n_cmp++; if (funct3 !== word[14:12]) begin n_err++; $display("FAIL rnd_f3[%0d] got %h want %h", t, funct3, word[14:12]); end
            n_cmp++; if (funct7 !== word[31:25]) begin n_err++; $display("FAIL rnd_f7[%0d] got %h want %h", t, funct7, word[31:25]); end
            n_cmp++; if (fetch_err !== 1'b0) begin n_err++; $display("FAIL rnd_err[%0d] got %b want 0", t, fetch_err); end
            bus.imem_ack = 1'b0;
            instr_ready  = 1'b1;
            Branch = b; Jump = j; Zero = z; ImmExt = imm;
            exp_pc = (j || (b && z)) ? exp_pc + imm : exp_pc + 32'd4;
            tick();
            clear_inputs();
        end
    endtask

    task automatic test_misalign;
        accept(1'b0, 1'b1, 1'b0, 32'h40 - exp_pc);
        n_cmp++; if (bus.imem_addr !== 32'h40) begin n_err++; $display("FAIL mis_setup_addr got %h want 00000040", bus.imem_addr); end
        exp_pc = 32'h40;
        accept(1'b0, 1'b1, 1'b0, 32'h6);
`ifdef FETCH_MISALIGN_CHECK_EN
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (fetch_err !== 1'b1) begin n_err++; $display("FAIL mis_err[%0d] got %b want 1", k, fetch_err); end
            n_cmp++; if (PC !== 32'h40) begin n_err++; $display("FAIL mis_pc[%0d] got %h want 00000040", k, PC); end
            n_cmp++; if (bus.imem_req !== 1'b0) begin n_err++; $display("FAIL mis_req[%0d] got %b want 0", k, bus.imem_req); end
            n_cmp++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL mis_valid[%0d] got %b want 0", k, instr_valid); end
            bus.imem_ack = 1'($urandom_range(0, 1));
            instr_ready  = 1'($urandom_range(0, 1));
            Jump         = 1'b1;
            tick();
        end
        clear_inputs();
`else
        n_cmp++; if (bus.imem_addr !== 32'h46) begin n_err++; $display("FAIL mis_addr got %h want 00000046", bus.imem_addr); end
        n_cmp++; if (bus.imem_req !== 1'b1) begin n_err++; $display("FAIL mis_req got %b want 1", bus.imem_req); end
        n_cmp++; if (fetch_err !== 1'b0) begin n_err++; $display("FAIL mis_err got %b want 0", fetch_err); end
`endif
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_sequential();
        test_branch();
        test_ack_delay();
        test_ready_stall();
        test_reset_mid();
        test_random();
        test_misalign();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
